// File: rtl/puls_evt_queue.sv
// puls_evt_queue: counts event strobes and replays them one at a time as
// single-cycle pulses into a pulse handshake synchronizer, waiting for the
// synchronizer ready to go low and come back high between pulses.
// Optional watchdog enabled by defining PULS_EVT_TMO_EN: if ready never drops
// after a pulse, the FSM gives up after TMO_CYC cycles and flags o_tmo.
module puls_evt_queue #(
    parameter int CNT_W   = 4,
    parameter int TMO_CYC = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_evt,
    input  logic             i_ready,
    input  logic             i_ovf_clr,
    output logic             o_puls,
    output logic [CNT_W-1:0] o_pend_cnt,
    output logic             o_busy,
    output logic             o_ovf
`ifdef PULS_EVT_TMO_EN
    ,
    output logic             o_tmo
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_HI = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Elaboration-time sanity check of the configuration.
    if (CNT_W < 1 || TMO_CYC < 1) begin : g_param_check
        $error("puls_evt_queue: CNT_W and TMO_CYC must be at least 1");
    end

    state_t           state;
    state_t           next_state;
    logic             puls_q;
    logic [CNT_W-1:0] pend_cnt;
    logic             ovf_q;
    logic             issue_go;
    logic             ovf_set;
    logic             tmo_hit;

`ifdef PULS_EVT_TMO_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_q;

    // Watchdog fires on the last allowed WAIT_LO cycle with ready still high.
    assign tmo_hit = (state == WAIT_LO) && i_ready
                     && (tmo_cnt == TMO_W'(TMO_CYC - 1));

    // Watchdog counter: counts WAIT_LO cycles with ready high, cleared elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if ((state == WAIT_LO) && i_ready && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= 1'b0;
        end else if (tmo_hit) begin
            tmo_q <= 1'b1;
        end
    end

    assign o_tmo = tmo_q;
`else
    assign tmo_hit = 1'b0;
`endif

    // State register.
    // NOTE: every flop here is reset asynchronously and assigned with <=, so
    // all state updates in a cycle see the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic for the issue / handshake sequence.
    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch forms.
        next_state = state;
        unique case (state)
            IDLE:    if ((pend_cnt != '0) && i_ready) next_state = ISSUE;
            ISSUE:   next_state = WAIT_LO;
            WAIT_LO: begin
                if (!i_ready)     next_state = WAIT_HI;
                else if (tmo_hit) next_state = IDLE;
            end
            WAIT_HI: if (i_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The edge entering ISSUE is the one that consumes a pending event.
    assign issue_go = (next_state == ISSUE);
    assign ovf_set  = i_evt && !issue_go && (pend_cnt == CNT_MAX);

    // Registered pulse: high exactly for the cycle spent in ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            puls_q <= 1'b0;
        end else begin
            puls_q <= issue_go;
        end
    end

    // Pending counter: +1 per event, -1 per issue, saturating at CNT_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_cnt <= '0;
        end else if (i_evt && !issue_go) begin
            if (pend_cnt != CNT_MAX) pend_cnt <= pend_cnt + CNT_W'(1);
        end else if (!i_evt && issue_go) begin
            pend_cnt <= pend_cnt - CNT_W'(1);
        end
    end

    // Sticky overflow flag; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end else if (i_ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    // Output decode.
    always_comb begin
        o_puls     = puls_q;
        o_pend_cnt = pend_cnt;
        o_ovf      = ovf_q;
        o_busy     = (state != IDLE);
    end

endmodule
